// File: rtl/tank_game_pkg.sv
// rtl/tank_game_pkg.sv - shared tank game constants and tank state type
package tank_game_pkg;

    localparam int N_TANKS_DEF   = 5;
    localparam int RELOAD_FRAMES = 60;
    localparam int AMMO_MAX_DEF  = 15;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        TS_DEAD,
        TS_READY,
        TS_COOLDOWN
    } tank_state_t;

endpackage

// File: rtl/bullet_fire_scheduler_rr_arbiter.sv
// rtl/bullet_fire_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Scan offsets from the far end so the lowest offset from ptr overwrites last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_fire_scheduler.sv
// rtl/bullet_fire_scheduler.sv - per-tank reload FSMs plus round-robin fire arbitration
// Optional ammo limiting is enabled by defining AMMO_LIMIT_EN.
module bullet_fire_scheduler
    import tank_game_pkg::*;
#(
    parameter int N_TANKS  = N_TANKS_DEF,
    parameter int RELOAD   = RELOAD_FRAMES,
    parameter int AMMO_MAX = AMMO_MAX_DEF
) (
    input  logic               clk_f,
    input  logic               rst,
    input  logic [N_TANKS-1:0] shoot,
    input  logic [N_TANKS-1:0] tank_alive,
    input  logic [N_TANKS-1:0] bullet_active,
    input  logic [N_TANKS-1:0] ammo_refill,
    output logic [N_TANKS-1:0] fire,
    output logic [2:0]         fire_id,
    output logic               fire_valid,
    output logic [N_TANKS-1:0] ready,
    output logic [N_TANKS-1:0] ammo_empty,
    output logic [15:0]        shots_total
);

    logic [N_TANKS-1:0] in_ready;
    logic [N_TANKS-1:0] has_ammo;
    logic [N_TANKS-1:0] eligible;
    logic [N_TANKS-1:0] grant;
    logic [2:0]         grant_idx;
    logic               grant_any;
    logic [2:0]         ptr;

    assign eligible = shoot & tank_alive & ~bullet_active & in_ready & has_ammo;
    assign ready    = in_ready & tank_alive;

    rr_arbiter #(
        .N  (N_TANKS),
        .IW (3)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    for (genvar i = 0; i < N_TANKS; i++) begin : g_tank
        tank_state_t state;
        logic [5:0]  cd;

        // Losing the tank overrides everything, including a grant in the same cycle.
        always_ff @(posedge clk_f) begin
            if (rst) begin
                state <= TS_READY;
                cd    <= 6'(RELOAD);
            end else if (!tank_alive[i]) begin
                state <= TS_DEAD;
                cd    <= 6'(RELOAD);
            end else begin
                case (state)
                    TS_DEAD: begin
                        state <= TS_READY;
                        cd    <= 6'(RELOAD);
                    end
                    TS_READY: begin
                        if (grant[i]) begin
                            state <= TS_COOLDOWN;
                            cd    <= '0;
                        end
                    end
                    TS_COOLDOWN: begin
                        if (cd == 6'(RELOAD - 1)) begin
                            state <= TS_READY;
                            cd    <= 6'(RELOAD);
                        end else begin
                            cd <= cd + 6'd1;
                        end
                    end
                    default: begin
                        state <= TS_READY;
                        cd    <= 6'(RELOAD);
                    end
                endcase
            end
        end

        assign in_ready[i] = (state == TS_READY);

`ifdef AMMO_LIMIT_EN
        logic [3:0] ammo;

        always_ff @(posedge clk_f) begin
            if (rst) begin
                ammo <= 4'(AMMO_MAX);
            end else if (ammo_refill[i]) begin
                ammo <= 4'(AMMO_MAX);
            end else if (grant[i] && ammo != 4'd0) begin
                ammo <= ammo - 4'd1;
            end
        end

        assign has_ammo[i]   = (ammo != 4'd0);
        assign ammo_empty[i] = (ammo == 4'd0);
`else
        assign has_ammo[i]   = 1'b1;
        assign ammo_empty[i] = 1'b0;
`endif
    end

`ifndef AMMO_LIMIT_EN
    logic unused_refill;
    assign unused_refill = ^ammo_refill;
`endif

    always_ff @(posedge clk_f) begin
        if (rst) begin
            fire        <= '0;
            fire_id     <= '0;
            fire_valid  <= 1'b0;
            shots_total <= '0;
            ptr         <= '0;
        end else begin
            fire       <= grant;
            fire_id    <= grant_idx;
            fire_valid <= grant_any;
            if (grant_any) begin
                ptr         <= (grant_idx == 3'(N_TANKS - 1)) ? 3'd0 : grant_idx + 3'd1;
                shots_total <= shots_total + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bullet_fire_scheduler.sv
// tb/tb_bullet_fire_scheduler.sv - table, directed and random checks against a timestamp model
module tb_bullet_fire_scheduler;

    localparam int NT       = 5;
    localparam int RELOAD   = 60;
    localparam int AMMO_MAX = 15;
`ifdef AMMO_LIMIT_EN
    localparam bit AMMO_EN = 1'b1;
`else
    localparam bit AMMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NT-1:0] shoot = '0;
    logic [NT-1:0] tank_alive = '1;
    logic [NT-1:0] bullet_active = '0;
    logic [NT-1:0] ammo_refill = '0;
    logic [NT-1:0] fire;
    logic [2:0]    fire_id;
    logic          fire_valid;
    logic [NT-1:0] ready;
    logic [NT-1:0] ammo_empty;
    logic [15:0]   shots_total;

    int errors = 0;
    int checks = 0;

    bullet_fire_scheduler dut (
        .clk_f         (clk),
        .rst           (rst),
        .shoot         (shoot),
        .tank_alive    (tank_alive),
        .bullet_active (bullet_active),
        .ammo_refill   (ammo_refill),
        .fire          (fire),
        .fire_id       (fire_id),
        .fire_valid    (fire_valid),
        .ready         (ready),
        .ammo_empty    (ammo_empty),
        .shots_total   (shots_total)
    );

    always #5 clk = ~clk;

    // Model: each tank remembers the edge number from which it may fire again.
    int ready_at[NT];
    bit dead[NT];
    int ammo[NT];
    int ptr;
    int shots;
    int edge_no;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    task automatic step(input logic r, input logic [NT-1:0] sh, input logic [NT-1:0] al,
                        input logic [NT-1:0] ba, input logic [NT-1:0] rf);
        logic [NT-1:0] elig;
        logic [NT-1:0] m_fire;
        logic [NT-1:0] m_ready;
        logic [NT-1:0] m_empty;
        int g;
        @(negedge clk);
        rst = r; shoot = sh; tank_alive = al; bullet_active = ba; ammo_refill = rf;
        m_fire = '0;
        g = -1;
        if (r) begin
            for (int i = 0; i < NT; i++) begin
                ready_at[i] = 0; dead[i] = 0; ammo[i] = AMMO_MAX;
            end
            ptr = 0; shots = 0;
        end else begin
            for (int i = 0; i < NT; i++)
                elig[i] = sh[i] && al[i] && !ba[i] && !dead[i] && edge_no >= ready_at[i]
                          && (!AMMO_EN || ammo[i] > 0);
            for (int off = 0; off < NT; off++)
                if (g < 0 && elig[(ptr + off) % NT]) g = (ptr + off) % NT;
            if (g >= 0) begin
                m_fire[g] = 1'b1;
                ptr = (g + 1) % NT;
                shots = (shots + 1) % 65536;
            end
            for (int i = 0; i < NT; i++) begin
                if (rf[i]) ammo[i] = AMMO_MAX;
                else if (g == i && ammo[i] > 0) ammo[i]--;
                if (!al[i]) dead[i] = 1;
                else if (dead[i]) begin dead[i] = 0; ready_at[i] = edge_no + 1; end
                else if (g == i) ready_at[i] = edge_no + RELOAD + 1;
            end
        end
        edge_no++;
        for (int i = 0; i < NT; i++) begin
            m_ready[i] = !dead[i] && edge_no >= ready_at[i] && al[i];
            m_empty[i] = AMMO_EN && ammo[i] == 0;
        end
        @(posedge clk);
        #1;
        chk("model_fire", 32'(fire), 32'(m_fire));
        chk("model_fire_valid", 32'(fire_valid), 32'(m_fire != 0));
        if (g >= 0) chk("model_fire_id", 32'(fire_id), 32'(g));
        chk("model_ready", 32'(ready), 32'(m_ready));
        chk("model_ammo_empty", 32'(ammo_empty), 32'(m_empty));
        chk("model_shots", 32'(shots_total), 32'(shots));
    endtask

    typedef struct {
        logic          r;
        logic [NT-1:0] sh;
        logic [NT-1:0] al;
        logic [NT-1:0] ba;
        logic [NT-1:0] ef;
        logic [NT-1:0] er;
        logic [15:0]   es;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        int cnt;
        edge_no = 0;
        for (int i = 0; i < NT; i++) begin ready_at[i] = 0; dead[i] = 0; ammo[i] = AMMO_MAX; end
        ptr = 0; shots = 0;

        tbl[0] = '{1'b1, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b11111, 16'd0};
        tbl[1] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b00001, 5'b11110, 16'd1};
        tbl[2] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b00010, 5'b11100, 16'd2};
        tbl[3] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b00100, 5'b11000, 16'd3};
        tbl[4] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b01000, 5'b10000, 16'd4};
        tbl[5] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b10000, 5'b00000, 16'd5};
        tbl[6] = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 16'd5};
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].r, tbl[k].sh, tbl[k].al, tbl[k].ba, 5'b0);
            chk($sformatf("tbl%0d_fire", k), 32'(fire), 32'(tbl[k].ef));
            chk($sformatf("tbl%0d_ready", k), 32'(ready), 32'(tbl[k].er));
            chk($sformatf("tbl%0d_shots", k), 32'(shots_total), 32'(tbl[k].es));
        end

        // Reload interval for a held request.
        step(1'b1, 5'b0, 5'b11111, 5'b0, 5'b0);
        chk("rst_fire_id", 32'(fire_id), 32'd0);
        step(1'b0, 5'b00001, 5'b11111, 5'b0, 5'b0);
        chk("t1_first_fire", 32'(fire), 32'b00001);
        n = 1;
        while (n <= 200) begin
            step(1'b0, 5'b00001, 5'b11111, 5'b0, 5'b0);
            if (fire[0]) break;
            n++;
        end
        chk("t1_interval", 32'(n), 32'd61);

        // Bullet in flight blocks a ready tank.
        step(1'b1, 5'b0, 5'b11111, 5'b0, 5'b0);
        step(1'b0, 5'b00100, 5'b11111, 5'b00100, 5'b0);
        chk("t3_blocked", 32'(fire), 32'd0);
        step(1'b0, 5'b00100, 5'b11111, 5'b00100, 5'b0);
        chk("t3_ready_kept", 32'(ready[2]), 32'd1);
        step(1'b0, 5'b00100, 5'b11111, 5'b00000, 5'b0);
        chk("t3_released", 32'(fire), 32'b00100);

        // Death mid-cooldown then revival.
        step(1'b1, 5'b0, 5'b11111, 5'b0, 5'b0);
        step(1'b0, 5'b01000, 5'b11111, 5'b0, 5'b0);
        chk("t4_fire3", 32'(fire), 32'b01000);
        for (int k = 0; k < 30; k++) step(1'b0, 5'b0, 5'b11111, 5'b0, 5'b0);
        chk("t4_cooling", 32'(ready[3]), 32'd0);
        step(1'b0, 5'b0, 5'b10111, 5'b0, 5'b0);
        chk("t4_dead", 32'(ready[3]), 32'd0);
        step(1'b0, 5'b0, 5'b11111, 5'b0, 5'b0);
        chk("t4_revived", 32'(ready[3]), 32'd1);
        step(1'b0, 5'b01000, 5'b11111, 5'b0, 5'b0);
        chk("t4_refire", 32'(fire), 32'b01000);

        // Death beats a same-cycle request; reset clears cooldown and a pending grant.
        step(1'b1, 5'b0, 5'b11111, 5'b0, 5'b0);
        step(1'b0, 5'b00010, 5'b11101, 5'b0, 5'b0);
        chk("t5_dead_wins", 32'(fire), 32'd0);
        step(1'b0, 5'b00010, 5'b11111, 5'b0, 5'b0);
        chk("t5_dead_no_fire", 32'(fire), 32'd0);
        step(1'b0, 5'b10000, 5'b11111, 5'b0, 5'b0);
        chk("t5_fire4", 32'(fire), 32'b10000);
        for (int k = 0; k < 10; k++) step(1'b0, 5'b0, 5'b11111, 5'b0, 5'b0);
        step(1'b1, 5'b11111, 5'b11111, 5'b0, 5'b0);
        chk("t5_rst_ready", 32'(ready), 32'b11111);
        chk("t5_rst_fire", 32'(fire), 32'd0);
        chk("t5_rst_shots", 32'(shots_total), 32'd0);

`ifdef AMMO_LIMIT_EN
        step(1'b1, 5'b0, 5'b11111, 5'b0, 5'b0);
        cnt = 0;
        n = 0;
        while (cnt < 15 && n < 15 * 61 + 20) begin
            step(1'b0, 5'b00001, 5'b11111, 5'b0, 5'b0);
            if (fire[0]) cnt++;
            n++;
        end
        chk("t6_shots", 32'(cnt), 32'd15);
        chk("t6_empty", 32'(ammo_empty[0]), 32'd1);
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 5'b00001, 5'b11111, 5'b0, 5'b0);
            if (fire[0]) cnt++;
        end
        chk("t6_no_fire_empty", 32'(cnt), 32'd0);
        step(1'b0, 5'b0, 5'b11111, 5'b0, 5'b00001);
        chk("t6_refilled", 32'(ammo_empty[0]), 32'd0);
        n = 0;
        while (n < 100) begin
            step(1'b0, 5'b00001, 5'b11111, 5'b0, 5'b0);
            if (fire[0]) break;
            n++;
        end
        chk("t6_resumed", 32'(fire[0]), 32'd1);
`endif

        // Random traffic against the model.
        step(1'b1, 5'b0, 5'b11111, 5'b0, 5'b0);
        for (int k = 0; k < 3000; k++) begin
            logic [NT-1:0] al;
            logic [NT-1:0] ba;
            logic [NT-1:0] rf;
            for (int i = 0; i < NT; i++) begin
                al[i] = ($urandom_range(0, 11) != 0);
                ba[i] = ($urandom_range(0, 3) == 0);
                rf[i] = ($urandom_range(0, 49) == 0);
            end
            step($urandom_range(0, 499) == 0, NT'($urandom), al, ba, rf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
